// File: rtl/dmem_pkg.sv
// -----------------------------------------------------------------------------
// dmem_pkg
// Shared constants and types for the data-memory responder.
//   ADDR_W / DATA_W       : core address (word) and data widths
//   RAM_WORDS             : number of RAM words below the MMIO window
//   ADDR_GPIO_OUT..STATUS : MMIO register addresses at the top of the map
//   state_e               : responder FSM states
// -----------------------------------------------------------------------------
package dmem_pkg;

   localparam int ADDR_W    = 10;
   localparam int DATA_W    = 32;
   localparam int RAM_WORDS = 1020;

   localparam logic [ADDR_W-1:0] RAM_LAST      = 10'h3FB;
   localparam logic [ADDR_W-1:0] ADDR_GPIO_OUT = 10'h3FC;
   localparam logic [ADDR_W-1:0] ADDR_GPIO_IN  = 10'h3FD;
   localparam logic [ADDR_W-1:0] ADDR_CYCLES   = 10'h3FE;
   localparam logic [ADDR_W-1:0] ADDR_STATUS   = 10'h3FF;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_e;

   // True when the word address falls inside the RAM region.
   function automatic logic is_ram_addr(input logic [ADDR_W-1:0] addr);
      return addr <= RAM_LAST;
   endfunction

endpackage

// File: rtl/dmem_responder_gpio_sync.sv
// -----------------------------------------------------------------------------
// gpio_sync
// Two-flop synchroniser for a bus of independent asynchronous inputs.
//   clk_i : destination clock
//   rst_i : synchronous active-high reset, clears both flop stages
//   d_i   : asynchronous inputs
//   q_o   : synchronised outputs, two clk_i edges behind d_i
// -----------------------------------------------------------------------------
module gpio_sync #(
   parameter int W = 32
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // NOTE: non-blocking (<=) in clocked blocks so each stage samples the
   // pre-edge value of the previous one; blocking would collapse the chain.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
// Single-cycle data memory for a soft core: 1020-word RAM plus four MMIO
// registers (GPIO out, synchronised GPIO in, free-running cycle counter,
// status). Reads are combinational, writes land on the rising CLK edge.
//
// Ports
//   CLK             : sole clock
//   RESET           : synchronous active-high reset
//   DIR_DMEM        : word address from core
//   DATA_WRITE_DMEM : store data
//   READ / WRITE    : one-cycle load / store strobes (may be high together)
//   DATA_READ_DMEM  : load data, 0 when READ is low
//   GPIO_IN         : asynchronous board inputs
//   GPIO_OUT        : registered board outputs
//   BUSY            : high while the post-reset RAM clear sweep runs
//
// Configuration
//   DMEM_CLEAR_EN defined   : after reset the FSM sits in CLEAR and zeroes the
//                             RAM one word per cycle; core accesses during the
//                             sweep read 0 and writes are dropped (setting ERR).
//   DMEM_CLEAR_EN undefined : no sweep, BUSY tied low, RAM starts undefined.
// -----------------------------------------------------------------------------
module dmem_responder
   import dmem_pkg::*;
(
   input  logic              CLK,
   input  logic              RESET,
   input  logic [ADDR_W-1:0] DIR_DMEM,
   input  logic [DATA_W-1:0] DATA_WRITE_DMEM,
   input  logic              READ,
   input  logic              WRITE,
   output logic [DATA_W-1:0] DATA_READ_DMEM,
   input  logic [DATA_W-1:0] GPIO_IN,
   output logic [DATA_W-1:0] GPIO_OUT,
   output logic              BUSY
);

   // NOTE: the RAM array is deliberately left out of every reset branch so it
   // maps onto block RAM; only the sweep (when built in) initialises it.
   logic [DATA_W-1:0] ram [RAM_WORDS];

   logic [DATA_W-1:0] gpio_out_q, gpio_out_d;
   logic [DATA_W-1:0] cycles_q,   cycles_d;
   logic              err_q,      err_d;
   logic [DATA_W-1:0] gpio_in_sync;
   logic [DATA_W-1:0] rdata;
   logic              busy;
   logic              core_wr_en;
   logic              ram_wr_en;

   // ---------------------------------------------------------------------------
   // Clear-sweep FSM
   // ---------------------------------------------------------------------------
`ifdef DMEM_CLEAR_EN
   state_e            state_q, state_d;
   logic [ADDR_W-1:0] sweep_q, sweep_d;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= ST_CLEAR;
         sweep_q <= '0;
      end else begin
         state_q <= state_d;
         sweep_q <= sweep_d;
      end
   end

   always_comb begin
      state_d = state_q;
      sweep_d = sweep_q;
      case (state_q)
         ST_CLEAR: begin
            if (sweep_q == RAM_LAST) begin
               state_d = ST_READY;
               sweep_d = '0;
            end else begin
               sweep_d = sweep_q + 1'b1;
            end
         end
         default: ;  // READY is terminal until RESET
      endcase
   end

   assign busy = (state_q == ST_CLEAR);
`else
   assign busy = 1'b0;
`endif

   assign core_wr_en = WRITE && !busy;
   assign ram_wr_en  = core_wr_en && is_ram_addr(DIR_DMEM);

   // ---------------------------------------------------------------------------
   // RAM write port: sweep has priority; core writes are already gated by busy.
   // The sweep is held off while RESET is high so reset alone never alters RAM.
   // ---------------------------------------------------------------------------
   always_ff @(posedge CLK) begin
`ifdef DMEM_CLEAR_EN
      if (busy && !RESET) begin
         ram[sweep_q] <= '0;
      end else if (ram_wr_en) begin
         ram[DIR_DMEM] <= DATA_WRITE_DMEM;
      end
`else
      if (ram_wr_en) begin
         ram[DIR_DMEM] <= DATA_WRITE_DMEM;
      end
`endif
   end

   // ---------------------------------------------------------------------------
   // MMIO registers
   // ---------------------------------------------------------------------------
   // NOTE: every always_comb output gets a default before any branch, so no
   // path can leave it unassigned and infer a latch.
   always_comb begin
      gpio_out_d = gpio_out_q;
      cycles_d   = cycles_q + 1'b1;
      err_d      = err_q;
      if (core_wr_en) begin
         case (DIR_DMEM)
            ADDR_GPIO_OUT: gpio_out_d = DATA_WRITE_DMEM;
            // Write loads 0 and the same cycle's increment still applies,
            // so the counter reads 1 on the following cycle.
            ADDR_CYCLES:   cycles_d   = 32'd1;
            ADDR_STATUS:   if (DATA_WRITE_DMEM[1]) err_d = 1'b0;
            default: ;
         endcase
      end
`ifdef DMEM_CLEAR_EN
      if (WRITE && busy) err_d = 1'b1;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         gpio_out_q <= '0;
         cycles_q   <= '0;
         err_q      <= 1'b0;
      end else begin
         gpio_out_q <= gpio_out_d;
         cycles_q   <= cycles_d;
         err_q      <= err_d;
      end
   end

   gpio_sync #(
      .W (DATA_W)
   ) u_gpio_sync (
      .clk_i (CLK),
      .rst_i (RESET),
      .d_i   (GPIO_IN),
      .q_o   (gpio_in_sync)
   );

   // ---------------------------------------------------------------------------
   // Zero-latency read mux; everything reads 0 while the sweep runs.
   // ---------------------------------------------------------------------------
   always_comb begin
      rdata = '0;
      if (READ && !busy) begin
         if (is_ram_addr(DIR_DMEM)) begin
            rdata = ram[DIR_DMEM];
         end else begin
            case (DIR_DMEM)
               ADDR_GPIO_OUT: rdata = gpio_out_q;
               ADDR_GPIO_IN:  rdata = gpio_in_sync;
               ADDR_CYCLES:   rdata = cycles_q;
               ADDR_STATUS:   rdata = {{(DATA_W-2){1'b0}}, err_q, busy};
               default:       rdata = '0;
            endcase
         end
      end
   end

   assign DATA_READ_DMEM = rdata;
   assign GPIO_OUT       = gpio_out_q;
   assign BUSY           = busy;

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
// Directed bench for dmem_responder. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge. The sweep-related
// steps are built only when DMEM_CLEAR_EN is defined.
// -----------------------------------------------------------------------------
module tb_dmem_responder;
   import dmem_pkg::*;

   logic              CLK = 1'b0;
   logic              RESET;
   logic [ADDR_W-1:0] DIR_DMEM;
   logic [DATA_W-1:0] DATA_WRITE_DMEM;
   logic              READ;
   logic              WRITE;
   logic [DATA_W-1:0] DATA_READ_DMEM;
   logic [DATA_W-1:0] GPIO_IN;
   logic [DATA_W-1:0] GPIO_OUT;
   logic              BUSY;

   int tests = 0;
   int fails = 0;

   dmem_responder dut (
      .CLK             (CLK),
      .RESET           (RESET),
      .DIR_DMEM        (DIR_DMEM),
      .DATA_WRITE_DMEM (DATA_WRITE_DMEM),
      .READ            (READ),
      .WRITE           (WRITE),
      .DATA_READ_DMEM  (DATA_READ_DMEM),
      .GPIO_IN         (GPIO_IN),
      .GPIO_OUT        (GPIO_OUT),
      .BUSY            (BUSY)
   );

   always #5 CLK = ~CLK;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RESET = 1'b1;
      READ  = 1'b0;
      WRITE = 1'b0;
      next_cycle();
      RESET = 1'b0;
   endtask

   task automatic wr(input logic [9:0] a, input logic [31:0] d);
      WRITE           = 1'b1;
      DIR_DMEM        = a;
      DATA_WRITE_DMEM = d;
      next_cycle();
      WRITE = 1'b0;
   endtask

   task automatic check_rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
      READ     = 1'b1;
      DIR_DMEM = a;
      @(negedge CLK);
      check(tag, DATA_READ_DMEM, exp);
      next_cycle();
      READ = 1'b0;
   endtask

   // Counts further BUSY-high cycles starting from 'start'; bounded.
   task automatic wait_ready(input int start, output int n);
      n = start;
      for (int i = 0; i < 2000; i++) begin
         @(negedge CLK);
         if (!BUSY) break;
         n++;
         next_cycle();
      end
      next_cycle();
   endtask

   initial begin
      int n;
      int bad;
      RESET           = 1'b1;
      READ            = 1'b0;
      WRITE           = 1'b0;
      DIR_DMEM        = '0;
      DATA_WRITE_DMEM = '0;
      GPIO_IN         = '0;
      do_reset();

`ifdef DMEM_CLEAR_EN
      // Cycle 0 after reset: sweeping, reads suppressed.
      READ     = 1'b1;
      DIR_DMEM = ADDR_CYCLES;
      @(negedge CLK);
      check("busy_after_reset", {31'b0, BUSY}, 32'h1);
      check("read_during_sweep", DATA_READ_DMEM, 32'h0);
      check("gpio_out_reset", GPIO_OUT, 32'h0);
      next_cycle();
      READ = 1'b0;
      wait_ready(1, n);
      check("busy_length", n, 32'd1020);
      bad = 0;
      for (int a = 0; a < RAM_WORDS; a++) begin
         READ     = 1'b1;
         DIR_DMEM = 10'(a);
         @(negedge CLK);
         if (DATA_READ_DMEM !== 32'h0) bad++;
         next_cycle();
      end
      READ = 1'b0;
      check("ram_cleared_bad_words", bad, 32'd0);
      check_rd("status_clean", ADDR_STATUS, 32'h0);
`else
      READ     = 1'b1;
      DIR_DMEM = ADDR_CYCLES;
      @(negedge CLK);
      check("cycles_after_reset", DATA_READ_DMEM, 32'h0);
      check("busy_after_reset", {31'b0, BUSY}, 32'h0);
      check("gpio_out_reset", GPIO_OUT, 32'h0);
      next_cycle();
      @(negedge CLK);
      check("cycles_increment", DATA_READ_DMEM, 32'h1);
      next_cycle();
      READ = 1'b0;
      @(negedge CLK);
      check("read_strobe_low", DATA_READ_DMEM, 32'h0);
      next_cycle();
      check_rd("status_ready", ADDR_STATUS, 32'h0);
`endif

      // RAM boundaries and basic store/load.
      wr(10'h3FB, 32'h7);
      check_rd("ram_top", 10'h3FB, 32'h7);
      wr(10'h000, 32'h11);
      check_rd("ram_bottom", 10'h000, 32'h11);
      wr(10'h005, 32'hDEADBEEF);
      check_rd("ram_wr_rd", 10'h005, 32'hDEADBEEF);

      // Same-cycle read+write returns the old word.
      READ            = 1'b1;
      WRITE           = 1'b1;
      DIR_DMEM        = 10'h005;
      DATA_WRITE_DMEM = 32'h1;
      @(negedge CLK);
      check("rw_same_cycle_old", DATA_READ_DMEM, 32'hDEADBEEF);
      next_cycle();
      WRITE = 1'b0;
      READ  = 1'b0;
      check_rd("rw_next_new", 10'h005, 32'h1);

      // GPIO_OUT register.
      WRITE           = 1'b1;
      DIR_DMEM        = ADDR_GPIO_OUT;
      DATA_WRITE_DMEM = 32'hA5A5_0001;
      @(negedge CLK);
      check("gpio_out_before_edge", GPIO_OUT, 32'h0);
      next_cycle();
      WRITE = 1'b0;
      READ  = 1'b1;
      @(negedge CLK);
      check("gpio_out_pin", GPIO_OUT, 32'hA5A5_0001);
      check("gpio_out_readback", DATA_READ_DMEM, 32'hA5A5_0001);
      next_cycle();

      // GPIO_IN synchroniser latency.
      GPIO_IN  = 32'h1234;
      DIR_DMEM = ADDR_GPIO_IN;
      @(negedge CLK);
      check("gpio_in_cycle0", DATA_READ_DMEM, 32'h0);
      next_cycle();
      @(negedge CLK);
      check("gpio_in_cycle1", DATA_READ_DMEM, 32'h0);
      next_cycle();
      @(negedge CLK);
      check("gpio_in_cycle2", DATA_READ_DMEM, 32'h1234);
      next_cycle();
      READ = 1'b0;
      wr(ADDR_GPIO_IN, 32'hFFFF_FFFF);
      check_rd("gpio_in_write_ignored", ADDR_GPIO_IN, 32'h1234);

      // Cycle counter clear.
      wr(ADDR_CYCLES, 32'hABC);
      check_rd("cycles_cleared", ADDR_CYCLES, 32'h1);
      check_rd("cycles_after_clear", ADDR_CYCLES, 32'h2);

      wr(ADDR_STATUS, 32'h2);
      check_rd("status_clear_noop", ADDR_STATUS, 32'h0);

`ifdef DMEM_CLEAR_EN
      // Write during sweep cycle 10 is dropped and flags ERR.
      do_reset();
      repeat (10) next_cycle();
      READ            = 1'b1;
      WRITE           = 1'b1;
      DIR_DMEM        = 10'h005;
      DATA_WRITE_DMEM = 32'h55;
      @(negedge CLK);
      check("rw_during_sweep", DATA_READ_DMEM, 32'h0);
      next_cycle();
      READ  = 1'b0;
      WRITE = 1'b0;
      wait_ready(11, n);
      check("busy_length_err", n, 32'd1020);
      check_rd("status_err", ADDR_STATUS, 32'h2);
      check_rd("dropped_write", 10'h005, 32'h0);
      wr(ADDR_STATUS, 32'h2);
      check_rd("status_err_cleared", ADDR_STATUS, 32'h0);

      // Reset mid-sweep restarts from index 0.
      do_reset();
      repeat (500) next_cycle();
      do_reset();
      wait_ready(0, n);
      check("busy_length_restart", n, 32'd1020);
`else
      // Reset alone leaves RAM intact and BUSY low.
      do_reset();
      @(negedge CLK);
      check("busy_after_reset2", {31'b0, BUSY}, 32'h0);
      next_cycle();
      check_rd("ram_kept_over_reset", 10'h005, 32'h1);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have ports: CLK  in  1  sole clock, all state updates on rising edge.
REQ-002 RESET  in  1  synchronous, active-high reset, sampled on CLK rising edge.
REQ-003 DIR_DMEM  in  10  word address from core.
REQ-004 DATA_WRITE_DMEM  in  32  store data from core.
REQ-005 READ  in  1  load strobe, one cycle per access.
REQ-006 WRITE  in  1  store strobe, one cycle per access.
REQ-007 DATA_READ_DMEM  out  32  load data to core, combinational from address.
REQ-008 GPIO_IN  in  32  asynchronous board inputs.
REQ-009 GPIO_OUT  out  32  registered board outputs.
REQ-010 BUSY  out  1  high while post-reset clear sweep runs; top level holds core in reset while high.

Function
REQ-011 Address map SHALL be: 0x000-0x3FB RAM (1020 words); 0x3FC GPIO_OUT reg (R/W); 0x3FD GPIO_IN synchronised (RO); 0x3FE cycle counter (R, write clears); 0x3FF status (bit0 BUSY, bit1 ERR sticky, others 0; write with bit1=1 clears ERR).
REQ-012 Reads SHALL be zero-latency: DATA_READ_DMEM valid in the same cycle READ and DIR_DMEM are presented; 32'h0 when READ=0.
REQ-013 Writes SHALL take effect at the rising edge ending the cycle WRITE=1; a read of the same address in that cycle returns the pre-write value.
REQ-014 READ and WRITE both high SHALL perform both per REQ-012/013.
REQ-015 Writes to 0x3FD SHALL be ignored; writes to 0x3FE SHALL load 0 (counter shows 1 the next cycle).
REQ-016 Cycle counter SHALL increment by 1 every cycle outside reset, wrapping 32'hFFFFFFFF -> 0.
REQ-017 GPIO_IN SHALL pass through a 2-flop synchroniser; reads of 0x3FD see input 2 cycles after change.
REQ-018 FSM states SHALL be CLEAR and READY; CLEAR writes 0 to RAM word index 0..1019, one word per cycle, then enters READY after word 1019 (1020 cycles).
REQ-019 In CLEAR: BUSY=1, all RAM/MMIO reads return 0, all core writes are dropped and set ERR=1.
REQ-020 In READY: BUSY=0; FSM stays in READY until RESET.

Reset
REQ-021 RESET SHALL set GPIO_OUT=0, counter=0, ERR=0, synchroniser flops=0, sweep index=0, FSM=CLEAR (macro defined) or READY (macro undefined).
REQ-022 RESET asserted mid-sweep SHALL restart the sweep from index 0.
REQ-023 RAM contents SHALL NOT be modified by RESET itself, only by the sweep.

Configuration
REQ-024 Macro DMEM_CLEAR_EN defined: CLEAR state and sweep counter SHALL be present per REQ-018/019.
REQ-025 DMEM_CLEAR_EN undefined: no sweep logic, BUSY tied 0, FSM always READY, RAM content after reset undefined (simulation X), ERR can never set.

Structure
REQ-026 Package dmem_pkg SHALL hold ADDR_W=10, DATA_W=32, RAM_WORDS=1020, MMIO address constants (ADDR_GPIO_OUT, ADDR_GPIO_IN, ADDR_CYCLES, ADDR_STATUS), and the FSM state enum.
REQ-027 Sub-module gpio_sync (parameterised 2-flop synchroniser) SHALL be used for GPIO_IN; all else in dmem_responder.

Verification
REQ-028 DMEM_CLEAR_EN, RESET 1 cycle -> BUSY=1 for exactly 1020 cycles; afterwards READ 0x000..0x3FB all return 0.
REQ-029 WRITE 0x005=32'hDEADBEEF, next cycle READ 0x005 -> 32'hDEADBEEF; same-cycle READ+WRITE 0x005=32'h1 -> reads 32'hDEADBEEF, next read 32'h1.
REQ-030 WRITE during sweep cycle 10 -> write dropped, status read after sweep = 32'h2; write 0x3FF=32'h2 -> status 32'h0.
REQ-031 RESET reasserted at sweep cycle 500 -> BUSY stays 1 for 1020 cycles after release.
REQ-032 Write 0x3FC=32'hA5A5_0001 -> GPIO_OUT=32'hA5A5_0001 next cycle; GPIO_IN=32'h1234 -> read 0x3FD =32'h1234 from 2nd cycle on; write 0x3FE -> read 0x3FE next cycle =1.
REQ-033 Without DMEM_CLEAR_EN: BUSY=0 from first cycle after reset, write/read 0x3FB=32'h7 returns 32'h7.
